// File: rtl/instr_encoder.sv
// RV32I instruction encoder: two-stage valid/ready pipeline that packs decoded
// fields into a 32-bit instruction word with format code and range-error flag.
module instr_encoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       op,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [2:0]       out_fmt,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [2:0] {
        FmtI   = 3'b000,
        FmtS   = 3'b001,
        FmtB   = 3'b010,
        FmtJ   = 3'b011,
        FmtU   = 3'b100,
        FmtR   = 3'b101,
        FmtBad = 3'b111
    } fmt_e;

    // Map an opcode to its immediate format.
    function automatic fmt_e classify(input logic [6:0] opc);
        fmt_e f;
        case (opc)
            OpReg:                    f = FmtR;
            OpImm, OpLoad, OpJalr:    f = FmtI;
            OpStore:                  f = FmtS;
            OpBranch:                 f = FmtB;
            OpJal:                    f = FmtJ;
            OpAuipc, OpLui:           f = FmtU;
            default:                  f = FmtBad;
        endcase
        return f;
    endfunction

    // Stage 1 registers
    logic        s1_valid_q;
    fmt_e        s1_fmt_q;
    logic [6:0]  s1_op_q;
    logic [4:0]  s1_rd_q;
    logic [4:0]  s1_rs1_q;
    logic [4:0]  s1_rs2_q;
    logic [2:0]  s1_f3_q;
    logic [6:0]  s1_f7_q;
    logic [31:0] s1_imm_q;

    // Handshake and stage-2 next values
    logic        s2_load;
    logic        in_accept;
    logic        out_xfer;
    logic [31:0] pack_d;
    logic        err_d;
    logic        fits12;
    logic        fits13;
    logic        fits21;

    // Pipeline flow control; S1 advances exactly when S2 loads.
    always_comb begin
        s2_load   = s1_valid_q && (!out_valid || out_ready);
        in_ready  = !reset && (!s1_valid_q || s2_load);
        in_accept = in_valid && in_ready;
        out_xfer  = out_valid && out_ready;
    end

    // Stage 1: capture fields and classify the opcode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_fmt_q   <= FmtI;
            s1_op_q    <= '0;
            s1_rd_q    <= '0;
            s1_rs1_q   <= '0;
            s1_rs2_q   <= '0;
            s1_f3_q    <= '0;
            s1_f7_q    <= '0;
            s1_imm_q   <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (in_accept) begin
                s1_fmt_q <= classify(op);
                s1_op_q  <= op;
                s1_rd_q  <= rd;
                s1_rs1_q <= rs1;
                s1_rs2_q <= rs2;
                s1_f3_q  <= funct3;
                s1_f7_q  <= funct7;
                s1_imm_q <= imm;
            end
        end
    end

    // Pack the word and evaluate immediate range/alignment for the S1 entry.
    always_comb begin
        // A value fits in N signed bits when all bits above N-1 equal the sign bit.
        fits12 = (s1_imm_q[31:11] == '0) || (s1_imm_q[31:11] == '1);
        fits13 = (s1_imm_q[31:12] == '0) || (s1_imm_q[31:12] == '1);
        fits21 = (s1_imm_q[31:20] == '0) || (s1_imm_q[31:20] == '1);
        pack_d = '0;
        err_d  = 1'b0;
        case (s1_fmt_q)
            FmtR: begin
                pack_d = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
            end
            FmtI: begin
                pack_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
                err_d  = !fits12;
            end
            FmtS: begin
                pack_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                          s1_imm_q[4:0], s1_op_q};
                err_d  = !fits12;
            end
            FmtB: begin
                pack_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                          s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
                err_d  = !fits13 || s1_imm_q[0];
            end
            FmtJ: begin
                pack_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                          s1_rd_q, s1_op_q};
                err_d  = !fits21 || s1_imm_q[0];
            end
            FmtU: begin
                pack_d = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
                err_d  = (s1_imm_q[11:0] != '0);
            end
            default: begin
                pack_d = '0;
                err_d  = 1'b1;
            end
        endcase
    end

    // Stage 2 output register; holds stable until the consumer takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_fmt   <= 3'b000;
            out_err   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            out_instr <= pack_d;
            out_fmt   <= s1_fmt_q;
            out_err   <= err_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating delivery and error counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (out_xfer) begin
            if (enc_count != CntMax) begin
                enc_count <= enc_count + CNT_W'(1);
            end
            if (out_err && (err_count != CntMax)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule
